// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed N-digit seven-segment display driver.
//               Scans one digit per SCAN_DIV-cycle slot and decodes hex
//               glyphs. New values are double-buffered and take effect only
//               at a frame wrap, so a digit never tears. Supports optional
//               leading-zero blanking and a guard interval at the start of
//               each slot that keeps all digits disabled to suppress ghosting.
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               value_i      - packed hex nibbles, nibble 0 = rightmost digit
//               dp_i         - per-digit decimal point, active-high
//               blank_lz_i   - leading-zero blanking enable (sampled on load)
//               load_i       - one-cycle strobe capturing value/dp/blank_lz
//               seg_o        - segments {g,f,e,d,c,b,a}, polarity per param
//               seg_dp_o     - decimal point, polarity per param
//               dig_en_o     - one-hot digit enable, polarity per param
//               frame_done_o - one-cycle pulse following each frame wrap
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    seg_dp_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    frame_done_o
);

    localparam int c_PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_PS_W-1:0]     c_PS_LAST  = c_PS_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  c_DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] c_DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PS_W-1:0]       prescaler_q, prescaler_d;
    logic [c_IDX_W-1:0]      idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] pend_value_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pend_blz_q;
    logic                    pend_valid_q, pend_valid_d;

    logic [4*NUM_DIGITS-1:0] act_value_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic                    act_blz_q;

    logic [6:0]              seg_q, seg_d;
    logic                    seg_dp_q, seg_dp_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_done_q;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_in_guard;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_zero_run;
    logic                    w_blank;
    logic [6:0]              w_glyph;

    assign w_tick = (prescaler_q == c_PS_LAST);
    assign w_wrap = w_tick && (idx_q == c_IDX_LAST);

    // With GUARD = 0 there is no blanking interval; the comparison is
    // elaborated only when it can actually be true.
    generate
        if (GUARD > 0) begin : g_guard
            assign w_in_guard = (prescaler_q < c_PS_W'(GUARD));
        end else begin : g_no_guard
            assign w_in_guard = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Hex glyph decode, active-high gfedcba with a = bit 0
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------------
    // Digit selection and leading-zero blanking for the current slot
    // ------------------------------------------------------------------------
    always_comb begin
        w_nibble   = 4'h0;
        w_dp_bit   = 1'b0;
        w_onehot   = '0;
        w_zero_run = 1'b1;
        w_blank    = 1'b0;

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == c_IDX_W'(k)) begin
                w_nibble    = act_value_q[4*k +: 4];
                w_dp_bit    = act_dp_q[k];
                w_onehot[k] = 1'b1;
            end
        end

        // Walk from the most significant digit down: a digit is a leading
        // zero while every nibble from it upward is zero. Digit 0 is excluded
        // so a zero value still shows a single "0".
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (act_value_q[4*k +: 4] == 4'h0);
            if ((idx_q == c_IDX_W'(k)) && w_zero_run && act_blz_q) begin
                w_blank = 1'b1;
            end
        end
    end

    assign w_glyph = hex_glyph(w_nibble);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        prescaler_d  = w_tick ? '0 : prescaler_q + 1'b1;
        idx_d        = idx_q;
        pend_valid_d = pend_valid_q;

        if (w_tick) begin
            idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load coinciding with the wrap keeps the flag set: the wrap
        // consumes the old pending data and the new data waits a frame.
        if (load_i) begin
            pend_valid_d = 1'b1;
        end else if (w_wrap) begin
            pend_valid_d = 1'b0;
        end

        if (w_blank) begin
            seg_d    = c_SEG_OFF;
            seg_dp_d = c_DP_OFF;
        end else begin
            seg_d    = (SEG_ACTIVE_LOW != 0) ? ~w_glyph : w_glyph;
            seg_dp_d = (SEG_ACTIVE_LOW != 0) ? ~w_dp_bit : w_dp_bit;
        end

        if (w_in_guard) begin
            dig_en_d = c_DIG_OFF;
        end else begin
            dig_en_d = (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blz_q    <= 1'b0;
            seg_q        <= c_SEG_OFF;
            seg_dp_q     <= c_DP_OFF;
            dig_en_q     <= c_DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= w_wrap;

            if (load_i) begin
                pend_value_q <= value_i;
                pend_dp_q    <= dp_i;
                pend_blz_q   <= blank_lz_i;
            end

            if (w_wrap && pend_valid_q) begin
                act_value_q <= pend_value_q;
                act_dp_q    <= pend_dp_q;
                act_blz_q   <= pend_blz_q;
            end
        end
    end

    assign seg_o        = seg_q;
    assign seg_dp_o     = seg_dp_q;
    assign dig_en_o     = dig_en_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire
